// File: rtl/morse_msg_sequencer_if.sv
// Message-buffer write port, control inputs and encoder handshake for the Morse sequencer.
// master = switch/key logic plus encoder side; slave = the sequencer itself.
interface morse_msg_sequencer_if #(
   parameter int ADDR_W = 3
);
   logic              WrEn;
   logic [ADDR_W-1:0] WrAddr;
   logic [2:0]        WrData;
   logic [ADDR_W:0]   MsgLen;
   logic              Start;
   logic              Stop;
   logic              Repeat;
   logic              LetterDone;
   logic [2:0]        Letter;
   logic              LetterGo;
   logic              Busy;
   logic              MsgDone;
   logic [ADDR_W-1:0] Index;
   logic [3:0]        State;

   modport master (
      output WrEn, WrAddr, WrData, MsgLen, Start, Stop, Repeat, LetterDone,
      input  Letter, LetterGo, Busy, MsgDone, Index, State
   );

   modport slave (
      input  WrEn, WrAddr, WrData, MsgLen, Start, Stop, Repeat, LetterDone,
      output Letter, LetterGo, Busy, MsgDone, Index, State
   );
endinterface

// File: rtl/morse_msg_sequencer.sv
// Feeds stored letters to the Morse encoder with letter/word gaps; first LetterGo one cycle after Start.
// Waits indefinitely on LetterDone (the encoder's only backpressure); Stop aborts to IDLE next cycle.
module morse_msg_sequencer #(
   parameter int DEPTH      = 8,
   parameter int ADDR_W     = 3,
   parameter int LETTER_GAP = 3,
   parameter int WORD_GAP   = 7
) (
   input logic                  Clock,
   input logic                  Resetn,
   morse_msg_sequencer_if.slave bus
);
   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_ISSUE = 4'd1;
   localparam logic [3:0] S_WAIT  = 4'd2;
   localparam logic [3:0] S_LGAP  = 4'd3;
   localparam logic [3:0] S_WGAP  = 4'd4;
   localparam logic [3:0] S_DONE  = 4'd5;

   localparam logic [2:0] BLANK = 3'b100;

   localparam int GAP_MAX = (LETTER_GAP > WORD_GAP) ? LETTER_GAP : WORD_GAP;
   localparam int CNT_W   = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;

   localparam logic [CNT_W-1:0]  LG_L     = CNT_W'(LETTER_GAP);
   localparam logic [CNT_W-1:0]  WG_L     = CNT_W'(WORD_GAP);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

   logic [3:0]        state;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W:0]   len;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        mem [DEPTH];

   logic [2:0]        cur;
   logic              last;
   logic              gap_end;
   logic              presenting;

   // Entries are stored already sanitized, so bit 2 alone marks a blank.
   always_comb begin
      cur = BLANK;
      if (int'(idx) < DEPTH) cur = mem[idx];
   end

   assign last       = ({1'b0, idx} == (len - LEN_ONE));
   assign gap_end    = (cnt <= CNT_ONE);
   assign presenting = ((state == S_ISSUE) || (state == S_WAIT)) && !bus.Stop;

   assign bus.Letter   = presenting ? cur : BLANK;
   assign bus.LetterGo = (state == S_ISSUE) && !bus.Stop && !cur[2];
   assign bus.Busy     = (state != S_IDLE);
   assign bus.MsgDone  = (state == S_DONE);
   assign bus.Index    = idx;
   assign bus.State    = state;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= BLANK;
      end else if (bus.WrEn && (state == S_IDLE) && (int'(bus.WrAddr) < DEPTH)) begin
         mem[bus.WrAddr] <= (bus.WrData > BLANK) ? BLANK : bus.WrData;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= S_IDLE;
         idx   <= '0;
         len   <= '0;
         cnt   <= '0;
      end else if (bus.Stop && (state != S_IDLE)) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.Start && !bus.Stop && (bus.MsgLen != '0)) begin
                  len   <= (bus.MsgLen > DEPTH_L) ? DEPTH_L : bus.MsgLen;
                  idx   <= '0;
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cur[2]) begin
                  cnt   <= WG_L;
                  state <= S_WGAP;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.LetterDone) begin
                  if (!last) begin
                     cnt   <= LG_L;
                     state <= S_LGAP;
                  end else if (bus.Repeat) begin
                     cnt   <= WG_L;
                     state <= S_WGAP;
                  end else begin
                     state <= S_DONE;
                  end
               end
            end
            S_LGAP: begin
               // A loaded value of 0 or 1 both leave after a single cycle here.
               if (gap_end) begin
                  cnt   <= '0;
                  idx   <= idx + IDX_ONE;
                  state <= S_ISSUE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            S_WGAP: begin
               if (gap_end) begin
                  cnt <= '0;
                  if (!last) begin
                     idx   <= idx + IDX_ONE;
                     state <= S_ISSUE;
                  end else if (bus.Repeat) begin
                     idx   <= '0;
                     state <= S_ISSUE;
                  end else begin
                     state <= S_DONE;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end
endmodule
